// File: rtl/sc_pkg.sv
// rtl/sc_pkg.sv - shared FSM state type and default window/result widths for the stochastic decoder
package sc_pkg;

  localparam int SC_WIN_LOG2_DEF = 8;
  localparam int SC_OUT_W_DEF    = 8;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } sc_state_e;

endpackage

// File: rtl/sc_ones_counter.sv
// rtl/sc_ones_counter.sv - bit/ones counters over one 2^WIN_LOG2-bit window with window-complete strobe
module sc_ones_counter
  import sc_pkg::*;
#(
  parameter int WIN_LOG2 = SC_WIN_LOG2_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              cnt_en,
  input  logic              sn_bit,
  output logic [WIN_LOG2:0] ones_next,
  output logic              win_done
);

  logic [WIN_LOG2-1:0] bit_cnt_q, bit_cnt_d;
  logic [WIN_LOG2:0]   ones_q, ones_d;

  always_comb begin
    ones_next = ones_q + (WIN_LOG2+1)'(sn_bit);
    win_done  = cnt_en & (&bit_cnt_q);
    bit_cnt_d = bit_cnt_q;
    ones_d    = ones_q;
    if (clr) begin
      bit_cnt_d = '0;
      ones_d    = '0;
    end else if (cnt_en) begin
      // The last bit is folded into ones_next for the result, then the window restarts at zero.
      if (win_done) begin
        bit_cnt_d = '0;
        ones_d    = '0;
      end else begin
        bit_cnt_d = bit_cnt_q + WIN_LOG2'(1);
        ones_d    = ones_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q <= '0;
      ones_q    <= '0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      ones_q    <= ones_d;
    end
  end

endmodule

// File: rtl/sc_stream_decoder.sv
// rtl/sc_stream_decoder.sv - windowed stochastic-stream decoder to unipolar/bipolar results
// Bipolar output is built only when SC_DECODER_BIPOLAR_EN is defined; otherwise bip_out is 0.
module sc_stream_decoder
  import sc_pkg::*;
#(
  parameter int WIN_LOG2 = SC_WIN_LOG2_DEF,
  parameter int OUT_W    = SC_OUT_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    run,
  input  logic                    sn_bit,
  input  logic                    sn_valid,
  output logic [OUT_W-1:0]        uni_out,
  output logic signed [OUT_W-1:0] bip_out,
  output logic                    out_valid,
  output logic                    busy
);

  if (OUT_W > WIN_LOG2) begin : g_bad_cfg
    $error("sc_stream_decoder: OUT_W must not exceed WIN_LOG2");
  end

  localparam logic [WIN_LOG2:0] UNI_MAX = (WIN_LOG2+1)'(2**OUT_W - 1);

  sc_state_e         state_q, state_d;
  logic [OUT_W-1:0]  uni_q, uni_d, uni_sat;
  logic              out_valid_q, out_valid_d;
  logic [WIN_LOG2:0] ones_next, ones_shr;
  logic              win_done;
  logic              cnt_en;

  // Counting needs run high, so an abort on the final bit never raises win_done.
  assign cnt_en = run & sn_valid;

  sc_ones_counter #(.WIN_LOG2(WIN_LOG2)) u_cnt (
    .clk      (clk),
    .rst      (rst_n),
    .clr      (~run),
    .cnt_en   (cnt_en),
    .sn_bit   (sn_bit),
    .ones_next(ones_next),
    .win_done (win_done)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (run && sn_valid) state_d = ACC;
      ACC:     if (!run) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ones_shr    = ones_next >> (WIN_LOG2 - OUT_W);
    uni_sat     = (ones_shr > UNI_MAX) ? UNI_MAX[OUT_W-1:0] : ones_shr[OUT_W-1:0];
    uni_d       = win_done ? uni_sat : uni_q;
    out_valid_d = win_done;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q     <= IDLE;
      uni_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      uni_q       <= uni_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef SC_DECODER_BIPOLAR_EN
  localparam int DW = WIN_LOG2 + 3;
  localparam logic signed [DW-1:0] BIP_OFFS = DW'(2**WIN_LOG2);
  localparam logic signed [DW-1:0] BIP_MAX  = DW'(2**(OUT_W-1) - 1);
  localparam logic signed [DW-1:0] BIP_MIN  = DW'(-(2**(OUT_W-1)));

  logic signed [DW-1:0]    bip_diff, bip_shr;
  logic signed [OUT_W-1:0] bip_sat, bip_q, bip_d;

  always_comb begin
    bip_diff = $signed({1'b0, ones_next, 1'b0}) - BIP_OFFS;
    bip_shr  = bip_diff >>> (WIN_LOG2 - OUT_W + 1);
    if (bip_shr > BIP_MAX)      bip_sat = BIP_MAX[OUT_W-1:0];
    else if (bip_shr < BIP_MIN) bip_sat = BIP_MIN[OUT_W-1:0];
    else                        bip_sat = bip_shr[OUT_W-1:0];
    bip_d = win_done ? bip_sat : bip_q;
  end

  always_ff @(posedge clk) begin
    if (rst_n) bip_q <= '0;
    else       bip_q <= bip_d;
  end

  assign bip_out = bip_q;
`else
  assign bip_out = '0;
`endif

  assign uni_out   = uni_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q == ACC);

endmodule

// File: tb/tb_sc_stream_decoder.sv
// tb/tb_sc_stream_decoder.sv - directed self-checking bench for sc_stream_decoder (WIN_LOG2=8, OUT_W=8)
module tb_sc_stream_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       run = 1'b0;
  logic       sn_bit = 1'b0;
  logic       sn_valid = 1'b0;
  logic [7:0] uni_out;
  logic [7:0] bip_out;
  logic       out_valid;
  logic       busy;

  int passed = 0;
  int total = 0;
  int cyc = 0;
  int pulse_cnt = 0;
  int last_pulse_cyc = -1;
  int last_valid_cyc = -1;

  always #5 clk = ~clk;

  sc_stream_decoder #(.WIN_LOG2(8), .OUT_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .sn_bit   (sn_bit),
    .sn_valid (sn_valid),
    .uni_out  (uni_out),
    .bip_out  (bip_out),
    .out_valid(out_valid),
    .busy     (busy)
  );

  function automatic logic [7:0] bip_exp(input logic [7:0] v);
`ifdef SC_DECODER_BIPOLAR_EN
    return v;
`else
    return 8'h00;
`endif
  endfunction

  task automatic tick(input logic r, input logic ru, input logic v, input logic b);
    rst_n = r; run = ru; sn_valid = v; sn_bit = b;
    @(posedge clk);
    #1;
    cyc++;
    if (out_valid === 1'b1) begin
      pulse_cnt++;
      last_pulse_cyc = cyc;
    end
  endtask

  // Valid bit i is 1 when i < n_ones; gaps carry sn_bit=1 so a counted gap shows up.
  task automatic feed(input int n_bits, input int n_ones, input bit gaps);
    for (int i = 0; i < n_bits; i++) begin
      if (gaps && ($urandom_range(0, 3) == 0)) tick(1'b0, 1'b1, 1'b0, 1'b1);
      tick(1'b0, 1'b1, 1'b1, (i < n_ones));
      last_valid_cyc = cyc;
    end
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    total++; if (uni_out !== 8'h00) $display("FAIL reset_uni got %0h exp 0", uni_out); else passed++;
    total++; if (bip_out !== 8'h00) $display("FAIL reset_bip got %0h exp 0", bip_out); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_ov got %b exp 0", out_valid); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else passed++;
    tick(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_all_ones();
    pulse_cnt = 0;
    feed(256, 256, 1'b0);
    total++; if (pulse_cnt !== 1) $display("FAIL ones_pulses got %0d exp 1", pulse_cnt); else passed++;
    total++; if (last_pulse_cyc !== last_valid_cyc) $display("FAIL ones_latency got cyc %0d exp %0d", last_pulse_cyc, last_valid_cyc); else passed++;
    total++; if (uni_out !== 8'd255) $display("FAIL ones_uni got %0d exp 255", uni_out); else passed++;
    total++; if (bip_out !== bip_exp(8'h7F)) $display("FAIL ones_bip got %0h exp %0h", bip_out, bip_exp(8'h7F)); else passed++;
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    total++; if (out_valid !== 1'b0) $display("FAIL ones_ov_drop got %b exp 0", out_valid); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL ones_busy_idle got %b exp 0", busy); else passed++;
  endtask

  task automatic test_all_zeros();
    pulse_cnt = 0;
    feed(256, 0, 1'b0);
    total++; if (pulse_cnt !== 1) $display("FAIL zeros_pulses got %0d exp 1", pulse_cnt); else passed++;
    total++; if (uni_out !== 8'd0) $display("FAIL zeros_uni got %0d exp 0", uni_out); else passed++;
    total++; if (bip_out !== bip_exp(8'h80)) $display("FAIL zeros_bip got %0h exp %0h", bip_out, bip_exp(8'h80)); else passed++;
    tick(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_gaps();
    pulse_cnt = 0;
    feed(256, 192, 1'b1);
    total++; if (pulse_cnt !== 1) $display("FAIL gaps_pulses got %0d exp 1", pulse_cnt); else passed++;
    total++; if (last_pulse_cyc !== last_valid_cyc) $display("FAIL gaps_latency got cyc %0d exp %0d", last_pulse_cyc, last_valid_cyc); else passed++;
    total++; if (uni_out !== 8'd192) $display("FAIL gaps_uni got %0d exp 192", uni_out); else passed++;
    total++; if (bip_out !== bip_exp(8'h40)) $display("FAIL gaps_bip got %0h exp %0h", bip_out, bip_exp(8'h40)); else passed++;
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 1'b0, 1'b1);
    total++; if (pulse_cnt !== 1) $display("FAIL gaps_extra_pulse got %0d exp 1", pulse_cnt); else passed++;
    tick(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_abort_restart();
    pulse_cnt = 0;
    feed(100, 100, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    total++; if (busy !== 1'b0) $display("FAIL abort_busy got %b exp 0", busy); else passed++;
    total++; if (uni_out !== 8'd192) $display("FAIL abort_uni_hold got %0d exp 192", uni_out); else passed++;
    total++; if (bip_out !== bip_exp(8'h40)) $display("FAIL abort_bip_hold got %0h exp %0h", bip_out, bip_exp(8'h40)); else passed++;
    feed(255, 255, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    total++; if (pulse_cnt !== 0) $display("FAIL abort_pulses got %0d exp 0", pulse_cnt); else passed++;
    feed(256, 128, 1'b0);
    total++; if (pulse_cnt !== 1) $display("FAIL restart_pulses got %0d exp 1", pulse_cnt); else passed++;
    total++; if (uni_out !== 8'd128) $display("FAIL restart_uni got %0d exp 128", uni_out); else passed++;
    total++; if (bip_out !== bip_exp(8'h00)) $display("FAIL restart_bip got %0h exp %0h", bip_out, bip_exp(8'h00)); else passed++;
    tick(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int first_pulse;
    pulse_cnt = 0;
    feed(256, 200, 1'b0);
    first_pulse = last_pulse_cyc;
    total++; if (uni_out !== 8'd200) $display("FAIL b2b_uni1 got %0d exp 200", uni_out); else passed++;
    total++; if (bip_out !== bip_exp(8'h48)) $display("FAIL b2b_bip1 got %0h exp %0h", bip_out, bip_exp(8'h48)); else passed++;
    feed(256, 64, 1'b0);
    total++; if (busy !== 1'b1) $display("FAIL b2b_busy got %b exp 1", busy); else passed++;
    total++; if (pulse_cnt !== 2) $display("FAIL b2b_pulses got %0d exp 2", pulse_cnt); else passed++;
    total++; if (last_pulse_cyc - first_pulse !== 256) $display("FAIL b2b_spacing got %0d exp 256", last_pulse_cyc - first_pulse); else passed++;
    total++; if (uni_out !== 8'd64) $display("FAIL b2b_uni2 got %0d exp 64", uni_out); else passed++;
    total++; if (bip_out !== bip_exp(8'hC0)) $display("FAIL b2b_bip2 got %0h exp %0h", bip_out, bip_exp(8'hC0)); else passed++;
    tick(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_window();
    pulse_cnt = 0;
    feed(50, 50, 1'b0);
    tick(1'b1, 1'b1, 1'b1, 1'b1);
    total++; if (uni_out !== 8'h00) $display("FAIL rstmid_uni got %0d exp 0", uni_out); else passed++;
    total++; if (bip_out !== 8'h00) $display("FAIL rstmid_bip got %0h exp 0", bip_out); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL rstmid_ov got %b exp 0", out_valid); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rstmid_busy got %b exp 0", busy); else passed++;
    feed(256, 10, 1'b0);
    total++; if (pulse_cnt !== 1) $display("FAIL rstmid_pulses got %0d exp 1", pulse_cnt); else passed++;
    total++; if (last_pulse_cyc !== last_valid_cyc) $display("FAIL rstmid_latency got cyc %0d exp %0d", last_pulse_cyc, last_valid_cyc); else passed++;
    total++; if (uni_out !== 8'd10) $display("FAIL rstmid_uni_after got %0d exp 10", uni_out); else passed++;
    total++; if (bip_out !== bip_exp(8'h8A)) $display("FAIL rstmid_bip_after got %0h exp %0h", bip_out, bip_exp(8'h8A)); else passed++;
    tick(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_all_zeros();
    test_gaps();
    test_abort_restart();
    test_back_to_back();
    test_reset_mid_window();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sc_stream_decoder.md
SC_STREAM_DECODER -- requirements
Module: sc_stream_decoder

Interface
REQ-001 SHALL have parameter WIN_LOG2, default 8: window length is 2^WIN_LOG2 valid stream bits.
REQ-002 SHALL have parameter OUT_W, default 8: result width; OUT_W <= WIN_LOG2 is required, otherwise elaboration error.
REQ-003 SHALL have port clk  input  1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1: reset, synchronous and active-high (1 = reset), despite the name.
REQ-005 SHALL have port run  input  1: decoding enable; low aborts and idles.
REQ-006 SHALL have port sn_bit  input  1: stochastic stream bit from the multiplier stage.
REQ-007 SHALL have port sn_valid  input  1: qualifies sn_bit for the current cycle.
REQ-008 SHALL have port uni_out  output  OUT_W: unipolar result, registered.
REQ-009 SHALL have port bip_out  output  OUT_W: signed two's-complement bipolar result, registered.
REQ-010 SHALL have port out_valid  output  1: one-cycle pulse when uni_out/bip_out update.
REQ-011 SHALL have port busy  output  1: high while in state ACC.

Function
REQ-012 SHALL implement FSM states IDLE and ACC; IDLE->ACC when run=1 and sn_valid=1, counting that bit; ACC->IDLE when run=0.
REQ-013 SHALL hold ones counter (WIN_LOG2+1 bits, range 0..2^WIN_LOG2, never wraps) and bit counter (WIN_LOG2 bits).
REQ-014 In ACC, each cycle with sn_valid=1 SHALL increment the bit counter and add sn_bit to the ones counter; sn_valid=0 SHALL hold both.
REQ-015 On the 2^WIN_LOG2-th valid bit SHALL latch results including that bit, assert out_valid for exactly the next cycle, and clear both counters; no bit is skipped between windows.
REQ-016 Back-to-back windows SHALL run without gap; the FSM stays in ACC.
REQ-017 uni_out SHALL be ones >> (WIN_LOG2-OUT_W), saturated to 2^OUT_W-1.
REQ-018 bip_out SHALL be (2*ones - 2^WIN_LOG2) >> (WIN_LOG2-OUT_W+1), arithmetic shift, saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-019 Latency: out_valid and the new results are visible one cycle after the edge that samples the last bit of the window.
REQ-020 run=0 mid-window SHALL discard the partial window (counters cleared, no out_valid); uni_out/bip_out keep their last values.
REQ-021 run=0 on the same cycle as the last valid bit: abort wins; no out_valid.
REQ-022 In IDLE, sn_bit/sn_valid SHALL be ignored unless run=1.

Reset
REQ-023 When rst_n=1 at a clock edge: state IDLE, counters 0, uni_out=0, bip_out=0, out_valid=0, busy=0.
REQ-024 Reset SHALL override run/sn_valid in the same cycle; a partial window is lost.

Configuration
REQ-025 Macro SC_DECODER_BIPOLAR_EN: defined -> bip_out computed per REQ-018; undefined -> bip_out tied to 0 and its arithmetic not synthesised; uni_out is unaffected either way.

Structure
REQ-026 Shared package sc_pkg SHALL hold the FSM state typedef (IDLE, ACC) and the default WIN_LOG2/OUT_W constants.
REQ-027 One sub-module sc_ones_counter SHALL hold the bit/ones counters and the window-complete strobe; scaling, saturation and the FSM stay in the top module.

Verification (WIN_LOG2=8, OUT_W=8, macro defined)
REQ-028 Bench: 256 valid bits all 1 -> out_valid pulse; uni_out=255 (saturated); bip_out=127 (saturated).
REQ-029 Bench: 256 valid bits all 0 -> uni_out=0; bip_out=-128.
REQ-030 Bench: 192 ones in 256 valid bits, with random sn_valid=0 gaps -> uni_out=192; bip_out=64; out_valid exactly once, one cycle after the 256th valid bit.
REQ-031 Bench: run dropped after 100 bits, then restarted with 128 ones in 256 bits -> no pulse for the aborted window; then uni_out=128, bip_out=0.
REQ-032 Bench: two consecutive windows, continuous sn_valid -> out_valid pulses exactly 256 cycles apart; second result is independent of the first.
REQ-033 Bench: rst_n=1 asserted mid-window -> all outputs 0 the next cycle; state IDLE; no out_valid.
